alu_pipe: RTL and testbench

//  Parametrised, registered successor to the combinational execute-stage ALU.

---
 rtl/alu_pipe.sv | 191 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Registered execute-stage ALU with valid/ready handshake on
//               both sides. Result, flags {Z,N,C,V} and the illegal-op
//               indication are registered together and held under
//               back-pressure.
//               Optional feature macro ALU_MUL_EN: when defined, op 14 is a
//               radix-2 shift-add multiply (WIDTH+1 clocks from accept);
//               when undefined, op 14 is reserved like op 15.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             illegal
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] c_op_mov  = 4'd0;
   localparam logic [3:0] c_op_not  = 4'd1;
   localparam logic [3:0] c_op_and  = 4'd2;
   localparam logic [3:0] c_op_add  = 4'd3;
   localparam logic [3:0] c_op_nor  = 4'd4;
   localparam logic [3:0] c_op_nand = 4'd5;
   localparam logic [3:0] c_op_sub  = 4'd6;
   localparam logic [3:0] c_op_slt  = 4'd7;
   localparam logic [3:0] c_op_sll  = 4'd8;
   localparam logic [3:0] c_op_srl  = 4'd9;
   localparam logic [3:0] c_op_sra  = 4'd10;
   localparam logic [3:0] c_op_sltu = 4'd11;
   localparam logic [3:0] c_op_xor  = 4'd12;
   localparam logic [3:0] c_op_or   = 4'd13;
`ifdef ALU_MUL_EN
   localparam logic [3:0] c_op_mul  = 4'd14;
   localparam logic [SHW:0] c_mul_steps = (SHW+1)'(WIDTH);

   typedef enum logic [0:0] {
      S_IDLE     = 1'b0,
      S_MUL_BUSY = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic [SHW:0]     r_cnt;
   logic             w_is_mul;
`endif

   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_flags;
   logic             r_illegal;

   logic             w_accept;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic             w_add_v;
   logic             w_sub_v;
   logic             w_slt;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_v;
   logic             w_ill;
   logic [3:0]       w_flags;

   // Shared adder/subtractor; subtraction is a + ~b + 1 so the carry-out is "a >= b unsigned"
   assign w_shamt = b[SHW-1:0];
   assign w_add   = {1'b0, a} + {1'b0, b};
   assign w_sub   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign w_add_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
   assign w_sub_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
   assign w_slt   = w_sub[WIDTH-1] ^ w_sub_v;

   // Single-cycle operation decode; reserved codes yield zero with the illegal marker
   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      w_ill = 1'b0;
      case (op)
         c_op_mov:  w_res = a;
         c_op_not:  w_res = ~a;
         c_op_and:  w_res = a & b;
         c_op_add:  begin w_res = w_add[WIDTH-1:0]; w_c = w_add[WIDTH]; w_v = w_add_v; end
         c_op_nor:  w_res = ~(a | b);
         c_op_nand: w_res = ~(a & b);
         c_op_sub:  begin w_res = w_sub[WIDTH-1:0]; w_c = w_sub[WIDTH]; w_v = w_sub_v; end
         c_op_slt:  begin w_res = {{(WIDTH-1){1'b0}}, w_slt}; w_c = w_sub[WIDTH]; w_v = w_sub_v; end
         c_op_sll:  w_res = a << w_shamt;
         c_op_srl:  w_res = a >> w_shamt;
         c_op_sra:  w_res = $signed(a) >>> w_shamt;
         c_op_sltu: begin w_res = {{(WIDTH-1){1'b0}}, ~w_sub[WIDTH]}; w_c = w_sub[WIDTH]; w_v = w_sub_v; end
         c_op_xor:  w_res = a ^ b;
         c_op_or:   w_res = a | b;
`ifdef ALU_MUL_EN
         c_op_mul:  w_res = '0;   // produced by the multi-cycle path, never loaded from here
`endif
         default:   w_ill = 1'b1;
      endcase
   end

   assign w_flags = {(w_res == '0), w_res[WIDTH-1], w_c, w_v};

   // Accept only when idle and the output slot is free or being drained this cycle
`ifdef ALU_MUL_EN
   assign in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
   assign w_is_mul = (op == c_op_mul);
`else
   assign in_ready = !r_out_valid || out_ready;
`endif
   assign w_accept = in_valid && in_ready;

   // Control state, multiplier sequencing and the registered output stage
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_flags     <= '0;
         r_illegal   <= 1'b0;
`ifdef ALU_MUL_EN
         r_state     <= S_IDLE;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
`endif
      end else begin
`ifdef ALU_MUL_EN
         if (w_accept && w_is_mul) begin
            // Accepting a multiply also completes any output handshake in flight
            r_state     <= S_MUL_BUSY;
            r_out_valid <= 1'b0;
            r_mcand     <= a;
            r_mplier    <= b;
            r_acc       <= '0;
            r_cnt       <= '0;
         end else
`endif
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_flags     <= w_flags;
            r_illegal   <= w_ill;
         end
`ifdef ALU_MUL_EN
         else if (r_state == S_MUL_BUSY) begin
            if (r_cnt == c_mul_steps) begin
               r_out_valid <= 1'b1;
               r_result    <= r_acc;
               r_flags     <= {(r_acc == '0), r_acc[WIDTH-1], 2'b00};
               r_illegal   <= 1'b0;
               r_state     <= S_IDLE;
            end else begin
               // One multiplier bit per clock; only the low WIDTH product bits are kept
               if (r_mplier[0]) begin
                  r_acc <= r_acc + r_mcand;
               end
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
            end
         end
`endif
         else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign flags     = r_flags;
   assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Directed self-checking bench for alu_pipe (WIDTH = 32).
//               Follows the ALU_MUL_EN build setting of the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  flags;
   logic        illegal;

   int n_vec  = 0;
   int n_fail = 0;

   alu_pipe #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op with out_ready=1 and look at the registered outputs one clock later
   task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic expect_out(input string tag, input logic [31:0] r, input logic [3:0] f,
                             input logic il);
      chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".result"}, result, r);
      chk({tag, ".flags"}, {28'd0, flags}, {28'd0, f});
      chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, il});
   endtask

   initial begin
      int bad;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 4'd0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst.result", result, 32'd0);
      chk("rst.flags", {28'd0, flags}, 32'd0);
      chk("rst.illegal", {31'd0, illegal}, 32'd0);
      chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;

      // Arithmetic and flag corner cases ({Z,N,C,V})
      send(4'd3, 32'h7FFF_FFFF, 32'd1);   expect_out("add_ovf",  32'h8000_0000, 4'b0101, 1'b0);
      send(4'd6, 32'd5, 32'd5);           expect_out("sub_eq",   32'd0,         4'b1010, 1'b0);
      send(4'd7, 32'hFFFF_FFFF, 32'd1);   expect_out("slt",      32'd1,         4'b0010, 1'b0);
      send(4'd11, 32'hFFFF_FFFF, 32'd1);  expect_out("sltu",     32'd0,         4'b1010, 1'b0);
      send(4'd10, 32'h8000_0000, 32'd4);  expect_out("sra",      32'hF800_0000, 4'b0100, 1'b0);
      send(4'd9, 32'h8000_0000, 32'd4);   expect_out("srl",      32'h0800_0000, 4'b0000, 1'b0);
      send(4'd8, 32'd1, 32'h0000_003F);   expect_out("sll_mask", 32'h8000_0000, 4'b0100, 1'b0);
      send(4'd3, 32'hFFFF_FFFF, 32'd1);   expect_out("add_carry",32'd0,         4'b1010, 1'b0);
      send(4'd6, 32'd0, 32'd1);           expect_out("sub_borrow",32'hFFFF_FFFF,4'b0100, 1'b0);
      send(4'd6, 32'h8000_0000, 32'd1);   expect_out("sub_ovf",  32'h7FFF_FFFF, 4'b0011, 1'b0);
      send(4'd12, 32'h0000_F0F0, 32'h0000_FF00); expect_out("xor", 32'h0000_0FF0, 4'b0000, 1'b0);
      send(4'd13, 32'h0000_F0F0, 32'h0000_FF00); expect_out("or",  32'h0000_FFF0, 4'b0000, 1'b0);
      send(4'd4, 32'd0, 32'd0);           expect_out("nor",      32'hFFFF_FFFF, 4'b0100, 1'b0);
      send(4'd5, 32'hFFFF_0000, 32'h0F0F_0F0F); expect_out("nand", 32'hF0F0_FFFF, 4'b0100, 1'b0);
      send(4'd2, 32'hFFFF_0000, 32'h0F0F_0F0F); expect_out("and",  32'h0F0F_0000, 4'b0000, 1'b0);
      send(4'd1, 32'h0000_FFFF, 32'd0);   expect_out("not",      32'hFFFF_0000, 4'b0100, 1'b0);
      send(4'd0, 32'd0, 32'd9);           expect_out("mov_zero", 32'd0,         4'b1000, 1'b0);
      send(4'd15, 32'd3, 32'd4);          expect_out("op15",     32'd0,         4'b1000, 1'b1);
      send(4'd3, 32'd2, 32'd2);           expect_out("ill_clear",32'd4,         4'b0000, 1'b0);
      @(negedge clk);
      chk("drop.out_valid", {31'd0, out_valid}, 32'd0);

      // Back-pressure: three ADDs, consumer stalled for a while
      out_ready = 1'b0;
      op = 4'd3; a = 32'd1; b = 32'd1; in_valid = 1'b1;
      #1 chk("bp.in_ready0", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk("bp.result1", result, 32'd2);
      chk("bp.in_ready1", {31'd0, in_ready}, 32'd0);
      a = 32'd2; b = 32'd2;
      @(negedge clk);
      chk("bp.hold1", result, 32'd2);
      chk("bp.hold_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      chk("bp.hold2", result, 32'd2);
      out_ready = 1'b1;
      #1 chk("bp.in_ready_rel", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk("bp.result2", result, 32'd4);
      chk("bp.valid2", {31'd0, out_valid}, 32'd1);
      a = 32'd3; b = 32'd3;
      @(negedge clk);
      chk("bp.result3", result, 32'd6);
      chk("bp.valid3", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp.drained", {31'd0, out_valid}, 32'd0);

      // Reset drops a pending, unconsumed result
      out_ready = 1'b0;
      send(4'd3, 32'd7, 32'd7);
      chk("rstpend.valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      chk("rstpend.dropped", {31'd0, out_valid}, 32'd0);

`ifdef ALU_MUL_EN
      // Multiply: busy for WIDTH+1 clocks, result visible after the final one
      @(negedge clk);
      op = 4'd14; a = 32'd1234; b = 32'd5678; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 33; i++) begin
         @(negedge clk);
         if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      end
      chk("mul.busy_cycles", bad, 32'd0);
      @(negedge clk);
      expect_out("mul", 32'd7006652, 4'b0000, 1'b0);

      // Reset during the 10th busy clock discards the product
      @(negedge clk);
      op = 4'd14; a = 32'd3; b = 32'd4; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mulrst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("mulrst.in_ready", {31'd0, in_ready}, 32'd1);
      send(4'd3, 32'd2, 32'd2);
      expect_out("mulrst.add", 32'd4, 4'b0000, 1'b0);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) bad++;
      end
      chk("mulrst.no_stray", bad, 32'd0);
`else
      // Without the multiplier op 14 is reserved
      send(4'd14, 32'd3, 32'd4);
      expect_out("op14_res", 32'd0, 4'b1000, 1'b1);
      bad = 0;
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
      chk("op14.drop", bad, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
